pucch_f1_mod_ctrl: RTL and testbench
====================================

Name: pucch_f1_mod_ctrl

Overview:
Sequencer for the PUCCH format 1 modulation stage. It accepts one UCI word of 1 bit (BPSK) or 2 bits (QPSK) and maps it to complex symbol d(0) in sfix16 (Q1.15). It then streams d(0) once per (symbol, subcarrier) slot, NSYM x NSC samples, to the downstream sequence multiplier under valid/ready flow control. It sits between the UCI source and the base-sequence/orthogonal-cover multiply.

Parameters:
NSC, 12, subcarriers per symbol (1..16)
NSYM, 4, PUCCH data symbols per occasion (1..7)
SYM_W, 3, width of o_sym_idx (>= clog2(NSYM))
SC_W, 4, width of o_sc_idx (>= clog2(NSC))

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_uci_valid  in  1  UCI word valid
o_uci_ready  out  1  controller can accept UCI
i_uci_nbits  in  1  0 = 1 bit (BPSK), 1 = 2 bits (QPSK)
i_uci_bits  in  2  b0 = bit[0], b1 = bit[1]; bit[1] ignored when nbits = 0
o_valid  out  1  output sample valid
i_ready  in  1  downstream ready
o_re  out  16  sfix16 real part of d(0)
o_im  out  16  sfix16 imaginary part of d(0)
o_sym_idx  out  SYM_W  symbol index of current sample
o_sc_idx  out  SC_W  subcarrier index of current sample
o_last  out  1  final sample of occasion (sym = NSYM-1, sc = NSC-1)

Behaviour:
- Single clock i_clk; i_rst synchronous, active-high.
- Reset: state IDLE; o_uci_ready=0 during reset cycle, 1 from first cycle after; o_valid=0, o_last=0; o_re=o_im=0; indices=0.
- Constants, Q1.15: P = 16'h5A82 (+23170), N = 16'hA57E (-23170).
- BPSK (nbits=0): b0=0 -> (P,P); b0=1 -> (N,N).
- QPSK (nbits=1): re = b0 ? N : P; im = b1 ? N : P.
- States: IDLE, MAP, STREAM.
- IDLE: o_uci_ready=1. On i_uci_valid & o_uci_ready, register bits/nbits and go to MAP.
- MAP: one cycle. Register o_re/o_im from the mapping, clear counters, set o_valid=1, go to STREAM.
- STREAM: o_valid=1; o_re/o_im held constant all occasion.
- STREAM, on i_ready: advance sc; at sc = NSC-1, wrap sc to 0 and increment sym.
- o_last is combinational from the registered indices: high only when sym=NSYM-1 and sc=NSC-1.
- Handshake on the o_last sample: o_valid=0, o_last=0, go to IDLE.
- Latency: UCI handshake in cycle t -> first o_valid in cycle t+2. o_uci_ready is low t+1 until the cycle after the final handshake. Minimum spacing between occasions is NSYM*NSC+2 cycles.
- Backpressure: while o_valid & !i_ready, all outputs hold, including o_re, o_im, indices and o_last.
- o_valid never drops mid-occasion except on reset.
- i_uci_valid outside IDLE is ignored; the source must hold it until ready.
- Reset mid-STREAM or mid-MAP: next cycle IDLE, o_valid=0, occasion discarded, no partial o_last.
- Degenerate NSC=1, NSYM=1: a single sample with o_last=1 on it.
- i_uci_bits[1] is don't-care for nbits=0 and must not affect outputs.

Decomposition:
- Shared package pucch_pkg holds:
  - constants PUCCH_MOD_POS=16'h5A82 and PUCCH_MOD_NEG=16'hA57E;
  - enum mod_e {MOD_BPSK, MOD_QPSK};
  - state enum ctrl_state_e {IDLE, MAP, STREAM}.
- One sub-module, pucch_f1_mapper: combinational (nbits, bits) -> (re, im). It reuses the existing bpsk mapper per component for QPSK (b0 -> re, b1 -> im).

Test Plan:
- Reset, then BPSK bits=2'b00 with i_ready=1 -> first o_valid 2 cycles after handshake; 48 samples of (16'h5A82,16'h5A82); o_last only on sym=3, sc=11.
- QPSK bits=2'b10, i_ready=1 -> all samples re=16'h5A82, im=16'hA57E; o_uci_ready returns 1 the cycle after the last handshake.
- BPSK bits=2'b11 (bit[1] don't-care), i_ready toggling 1,0,0,1,... -> re=im=16'hA57E. All 48 index pairs appear exactly once in order; outputs are stable during stalls.
- i_uci_valid held high with a new word during STREAM -> ignored; accepted only once IDLE; second occasion carries the new word's values.
- Assert i_rst at sample 20 of an occasion -> o_valid=0 next cycle, no o_last emitted. A new UCI after reset streams a full 48-sample occasion.
- Hold i_ready=0 on the o_last sample for 5 cycles -> o_last, o_valid and indices (3,11) hold. Exit to IDLE only after i_ready=1.

Source files
------------

// File: rtl/pucch_pkg.sv
// Shared constants and types for the PUCCH format 1 modulation stage.
// Symbol amplitudes are +/- 1/sqrt(2) in sfix16 Q1.15.
package pucch_pkg;

  localparam logic [15:0] PUCCH_MOD_POS = 16'h5A82;
  localparam logic [15:0] PUCCH_MOD_NEG = 16'hA57E;

  typedef enum logic {
    MOD_BPSK = 1'b0,
    MOD_QPSK = 1'b1
  } mod_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MAP    = 2'd1,
    STREAM = 2'd2
  } ctrl_state_e;

  // Single-bit BPSK mapping; QPSK applies it independently per component.
  function automatic logic [15:0] bpsk_map(input logic b);
    return b ? PUCCH_MOD_NEG : PUCCH_MOD_POS;
  endfunction

endpackage

// File: rtl/pucch_f1_mod_ctrl_if.sv
// UCI input and sample output handshake bundle of the PUCCH F1 modulation controller.
// The slave modport is the controller; the master modport is its environment.
interface pucch_f1_mod_ctrl_if #(
  parameter int SYM_W = 3,
  parameter int SC_W  = 4
);
  logic             i_uci_valid;
  logic             o_uci_ready;
  logic             i_uci_nbits;
  logic [1:0]       i_uci_bits;
  logic             o_valid;
  logic             i_ready;
  logic [15:0]      o_re;
  logic [15:0]      o_im;
  logic [SYM_W-1:0] o_sym_idx;
  logic [SC_W-1:0]  o_sc_idx;
  logic             o_last;

  modport slave (
    input  i_uci_valid, i_uci_nbits, i_uci_bits, i_ready,
    output o_uci_ready, o_valid, o_re, o_im, o_sym_idx, o_sc_idx, o_last
  );

  modport master (
    output i_uci_valid, i_uci_nbits, i_uci_bits, i_ready,
    input  o_uci_ready, o_valid, o_re, o_im, o_sym_idx, o_sc_idx, o_last
  );
endinterface

// File: rtl/pucch_f1_mapper.sv
// Combinational UCI-to-d(0) mapper. BPSK drives both components from b0;
// QPSK maps b0 to the real part and b1 to the imaginary part.
module pucch_f1_mapper
  import pucch_pkg::*;
(
  input  mod_e        mod_i,
  input  logic [1:0]  bits_i,
  output logic [15:0] re_o,
  output logic [15:0] im_o
);

  always_comb begin
    re_o = bpsk_map(bits_i[0]);
    im_o = (mod_i == MOD_QPSK) ? bpsk_map(bits_i[1]) : bpsk_map(bits_i[0]);
  end

endmodule

// File: rtl/pucch_f1_mod_ctrl.sv
// PUCCH format 1 modulation sequencer: latches one UCI word, maps it to d(0)
// and streams it once per (symbol, subcarrier) slot under valid/ready.
module pucch_f1_mod_ctrl
  import pucch_pkg::*;
#(
  parameter int NSC   = 12,
  parameter int NSYM  = 4,
  parameter int SYM_W = 3,
  parameter int SC_W  = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  pucch_f1_mod_ctrl_if.slave  bus
);

  ctrl_state_e      state_q, state_d;
  mod_e             mod_q, mod_d;
  logic [1:0]       bits_q, bits_d;
  logic [15:0]      re_q, re_d;
  logic [15:0]      im_q, im_d;
  logic             valid_q, valid_d;
  logic [SYM_W-1:0] sym_q, sym_d;
  logic [SC_W-1:0]  sc_q, sc_d;

  logic [15:0] map_re;
  logic [15:0] map_im;
  logic        sc_end;
  logic        sym_end;
  logic        accept;
  logic        advance;

  pucch_f1_mapper u_mapper (
    .mod_i  (mod_q),
    .bits_i (bits_q),
    .re_o   (map_re),
    .im_o   (map_im)
  );

  assign sc_end  = (sc_q == SC_W'(NSC - 1));
  assign sym_end = (sym_q == SYM_W'(NSYM - 1));
  assign accept  = bus.i_uci_valid && bus.o_uci_ready;
  assign advance = valid_q && bus.i_ready;

  // Ready is gated by reset so the source never sees an accept during the reset cycle.
  assign bus.o_uci_ready = (state_q == IDLE) && !i_rst;
  // Gating with valid keeps o_last low in IDLE even when NSC = NSYM = 1.
  assign bus.o_last      = valid_q && sc_end && sym_end;
  assign bus.o_valid     = valid_q;
  assign bus.o_re        = re_q;
  assign bus.o_im        = im_q;
  assign bus.o_sym_idx   = sym_q;
  assign bus.o_sc_idx    = sc_q;

  always_comb begin
    state_d = state_q;
    mod_d   = mod_q;
    bits_d  = bits_q;
    re_d    = re_q;
    im_d    = im_q;
    valid_d = valid_q;
    sym_d   = sym_q;
    sc_d    = sc_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mod_d   = mod_e'(bus.i_uci_nbits);
          bits_d  = bus.i_uci_bits;
          state_d = MAP;
        end
      end
      MAP: begin
        re_d    = map_re;
        im_d    = map_im;
        sym_d   = '0;
        sc_d    = '0;
        valid_d = 1'b1;
        state_d = STREAM;
      end
      STREAM: begin
        if (advance) begin
          if (sc_end && sym_end) begin
            valid_d = 1'b0;
            sym_d   = '0;
            sc_d    = '0;
            state_d = IDLE;
          end else if (sc_end) begin
            sc_d  = '0;
            sym_d = sym_q + SYM_W'(1);
          end else begin
            sc_d = sc_q + SC_W'(1);
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      mod_q   <= MOD_BPSK;
      bits_q  <= '0;
      re_q    <= '0;
      im_q    <= '0;
      valid_q <= 1'b0;
      sym_q   <= '0;
      sc_q    <= '0;
    end else begin
      state_q <= state_d;
      mod_q   <= mod_d;
      bits_q  <= bits_d;
      re_q    <= re_d;
      im_q    <= im_d;
      valid_q <= valid_d;
      sym_q   <= sym_d;
      sc_q    <= sc_d;
    end
  end

endmodule

// File: tb/tb_pucch_f1_mod_ctrl.sv
// Self-checking bench for pucch_f1_mod_ctrl: table-driven occasions plus
// hand-written reset, ignore-while-busy and stall-on-last sequences.
module tb_pucch_f1_mod_ctrl;

  localparam int NSC   = 12;
  localparam int NSYM  = 4;
  localparam int SYM_W = 3;
  localparam int SC_W  = 4;
  localparam int NSAMP = NSC * NSYM;
  localparam logic [15:0] P = 16'h5A82;
  localparam logic [15:0] N = 16'hA57E;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] pendRe = P;
  logic [15:0] pendIm = P;

  typedef struct {
    logic [15:0]      re;
    logic [15:0]      im;
    logic [SYM_W-1:0] sym;
    logic [SC_W-1:0]  sc;
    logic             last;
  } sample_t;

  typedef struct {
    logic        nbits;
    logic [1:0]  bits;
    int          mode;
    logic [15:0] expRe;
    logic [15:0] expIm;
  } vec_t;

  sample_t sbQ[$];
  sample_t monE;
  sample_t newE;
  vec_t    vecs[6];
  logic        stallValid = 1'b0;
  logic [63:0] stallSnap;
  logic [63:0] curSnap;

  pucch_f1_mod_ctrl_if #(.SYM_W(SYM_W), .SC_W(SC_W)) bus ();

  pucch_f1_mod_ctrl #(
    .NSC   (NSC),
    .NSYM  (NSYM),
    .SYM_W (SYM_W),
    .SC_W  (SC_W)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push a full occasion on each UCI handshake, pop on each output handshake.
  always @(negedge clk) begin
    curSnap = {23'd0, bus.o_valid, bus.o_re, bus.o_im, bus.o_sym_idx, bus.o_sc_idx, bus.o_last};
    if (rst) begin
      sbQ.delete();
      stallValid = 1'b0;
    end else begin
      if (stallValid)
        checkOutput("stall_hold", curSnap, stallSnap);
      if (bus.i_uci_valid && bus.o_uci_ready) begin
        for (int s = 0; s < NSYM; s++) begin
          for (int c = 0; c < NSC; c++) begin
            newE.re   = pendRe;
            newE.im   = pendIm;
            newE.sym  = SYM_W'(s);
            newE.sc   = SC_W'(c);
            newE.last = (s == NSYM - 1) && (c == NSC - 1);
            sbQ.push_back(newE);
          end
        end
      end
      if (bus.o_valid && bus.i_ready) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_sample", curSnap, 64'd0);
        end else begin
          monE = sbQ.pop_front();
          checkOutput("sample",
                      {24'd0, bus.o_re, bus.o_im, bus.o_sym_idx, bus.o_sc_idx, bus.o_last},
                      {24'd0, monE.re, monE.im, monE.sym, monE.sc, monE.last});
        end
      end
      stallValid = bus.o_valid && !bus.i_ready;
      stallSnap  = curSnap;
    end
  end

  task automatic applyStimulus(input logic nbits, input logic [1:0] bits,
                               input logic [15:0] expRe, input logic [15:0] expIm);
    int n;
    pendRe = expRe;
    pendIm = expIm;
    bus.i_uci_nbits = nbits;
    bus.i_uci_bits  = bits;
    bus.i_uci_valid = 1'b1;
    n = 0;
    while (!bus.o_uci_ready && n < 200) begin
      tick();
      n++;
    end
    checkOutput("uci_ready_wait", 64'(bus.o_uci_ready), 64'd1);
    tick();
    bus.i_uci_valid = 1'b0;
    checkOutput("map_cycle", {62'd0, bus.o_valid, bus.o_uci_ready}, 64'd0);
    tick();
    checkOutput("first_valid_t2", 64'(bus.o_valid), 64'd1);
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating
  task automatic streamSamples(input int mode);
    int   k;
    logic leak;
    k    = 0;
    leak = 1'b0;
    while (sbQ.size() > 0 && k < 2000) begin
      bus.i_ready = (mode == 0) ? 1'b1 : (k % 3 == 0);
      if (bus.o_uci_ready) leak = 1'b1;
      tick();
      k++;
    end
    bus.i_ready = 1'b0;
    checkOutput("stream_done", 64'(sbQ.size()), 64'd0);
    checkOutput("ready_low_stream", 64'(leak), 64'd0);
    checkOutput("post_last", {61'd0, bus.o_uci_ready, bus.o_valid, bus.o_last}, 64'd4);
  endtask

  initial begin
    int k;
    vecs[0] = '{nbits: 1'b0, bits: 2'b00, mode: 0, expRe: P, expIm: P};
    vecs[1] = '{nbits: 1'b1, bits: 2'b10, mode: 0, expRe: P, expIm: N};
    vecs[2] = '{nbits: 1'b0, bits: 2'b11, mode: 1, expRe: N, expIm: N};
    vecs[3] = '{nbits: 1'b1, bits: 2'b01, mode: 1, expRe: N, expIm: P};
    vecs[4] = '{nbits: 1'b1, bits: 2'b11, mode: 0, expRe: N, expIm: N};
    vecs[5] = '{nbits: 1'b0, bits: 2'b10, mode: 0, expRe: P, expIm: P};

    rst = 1'b1;
    bus.i_uci_valid = 1'b0;
    bus.i_uci_nbits = 1'b0;
    bus.i_uci_bits  = 2'b00;
    bus.i_ready     = 1'b0;
    tick();
    tick();
    checkOutput("rst_outputs",
                {22'd0, bus.o_valid, bus.o_last, bus.o_uci_ready, bus.o_re, bus.o_im,
                 bus.o_sym_idx, bus.o_sc_idx}, 64'd0);
    rst = 1'b0;
    tick();
    checkOutput("rst_ready_after", 64'(bus.o_uci_ready), 64'd1);

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].nbits, vecs[v].bits, vecs[v].expRe, vecs[v].expIm);
      streamSamples(vecs[v].mode);
    end

    // A new word held during STREAM must wait for IDLE and then carry its own values.
    applyStimulus(1'b0, 2'b00, P, P);
    pendRe = P;
    pendIm = N;
    bus.i_uci_nbits = 1'b1;
    bus.i_uci_bits  = 2'b10;
    bus.i_uci_valid = 1'b1;
    streamSamples(0);
    applyStimulus(1'b1, 2'b10, P, N);
    streamSamples(0);

    // Reset while sample 20 is on the bus.
    applyStimulus(1'b0, 2'b00, P, P);
    k = 0;
    while (sbQ.size() > NSAMP - 20 && k < 500) begin
      bus.i_ready = 1'b1;
      tick();
      k++;
    end
    checkOutput("rst_mid_pos", {32'd0, bus.o_valid, bus.o_sym_idx, bus.o_sc_idx, 24'd0},
                {32'd0, 1'b1, 3'd1, 4'd8, 24'd0});
    rst = 1'b1;
    tick();
    checkOutput("rst_mid_out", {61'd0, bus.o_valid, bus.o_last, bus.o_uci_ready}, 64'd0);
    checkOutput("rst_mid_flush", 64'(sbQ.size()), 64'd0);
    rst = 1'b0;
    bus.i_ready = 1'b0;
    tick();
    checkOutput("rst_mid_idle",
                {54'd0, bus.o_valid, bus.o_last, bus.o_uci_ready, bus.o_sym_idx, bus.o_sc_idx},
                {54'd0, 1'b0, 1'b0, 1'b1, 3'd0, 4'd0});
    applyStimulus(1'b1, 2'b11, N, N);
    streamSamples(0);

    // Hold ready low on the final sample.
    applyStimulus(1'b1, 2'b01, N, P);
    k = 0;
    while (sbQ.size() > 1 && k < 500) begin
      bus.i_ready = 1'b1;
      tick();
      k++;
    end
    bus.i_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stall_last",
                  {55'd0, bus.o_valid, bus.o_last, bus.o_sym_idx, bus.o_sc_idx},
                  {55'd0, 1'b1, 1'b1, 3'd3, 4'd11});
    end
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    checkOutput("stall_exit", {61'd0, bus.o_uci_ready, bus.o_valid, bus.o_last}, 64'd4);
    checkOutput("stall_q_empty", 64'(sbQ.size()), 64'd0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
